rv_decode: RTL and testbench

RV_DECODE -- requirements
Module: rv_decode

---
 rtl/rv_decode.sv | 154 +++++++++++++++
 tb/tb_rv_decode.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode.sv
// RV32/64 base-integer decode stage: one registered output slot with an
// optional one-entry skid buffer so in_ready can come straight from a flop.
module rv_decode #(
    parameter int                  XLEN      = 32,
    parameter int                  PC_WIDTH  = 9,
    parameter logic [PC_WIDTH-1:0] BOOT_ADDR = PC_WIDTH'(32'h2000),
    parameter bit                  SKID      = 1'b0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_ir,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [XLEN-1:0]     out_imm,
    output logic [3:0]          out_funct,
    output logic [1:0]          out_target,
    output logic                out_illegal,
    output logic [31:0]         out_ir,
    output logic [PC_WIDTH-1:0] out_pc
);

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [6:0]  LUI    = 7'b0110111;
    localparam logic [6:0]  AUIPC  = 7'b0010111;
    localparam logic [6:0]  JAL    = 7'b1101111;
    localparam logic [6:0]  JALR   = 7'b1100111;
    localparam logic [6:0]  BRANCH = 7'b1100011;
    localparam logic [6:0]  LOAD   = 7'b0000011;
    localparam logic [6:0]  STORE  = 7'b0100011;
    localparam logic [6:0]  OP_IMM = 7'b0010011;
    localparam logic [6:0]  OP     = 7'b0110011;

    localparam logic [1:0] TGT_JALR  = 2'd0;
    localparam logic [1:0] TGT_JBXX  = 2'd1;
    localparam logic [1:0] TGT_PLUS4 = 2'd2;

    typedef struct packed {
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [3:0]      funct;
        logic [1:0]      target;
        logic            illegal;
    } dec_t;

    // Full 7-bit opcode compare also rejects words with ir[1:0] != 2'b11.
    function automatic dec_t decode(input logic [31:0] ir);
        dec_t d;
        d.rd      = ir[11:7];
        d.rs1     = ir[19:15];
        d.rs2     = ir[24:20];
        d.imm     = '0;
        d.funct   = 4'b0000;
        d.target  = TGT_PLUS4;
        d.illegal = 1'b0;
        case (ir[6:0])
            OP_IMM: begin
                d.imm   = XLEN'($signed(ir[31:20]));
                d.funct = (ir[14:12] == 3'b101) ? {ir[30], ir[14:12]} : {1'b0, ir[14:12]};
            end
            LOAD:   d.imm = XLEN'($signed(ir[31:20]));
            JALR: begin
                d.imm    = XLEN'($signed(ir[31:20]));
                d.target = TGT_JALR;
            end
            STORE:  d.imm = XLEN'($signed({ir[31:25], ir[11:7]}));
            BRANCH: begin
                d.imm    = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
                d.target = TGT_JBXX;
            end
            LUI, AUIPC: d.imm = XLEN'($signed({ir[31:12], 12'b0}));
            JAL: begin
                d.imm    = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
                d.target = TGT_JBXX;
            end
            OP:      d.funct   = {ir[30], ir[14:12]};
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    logic                out_valid_q;
    logic [31:0]         ir_q;
    logic [PC_WIDTH-1:0] pc_q;
    dec_t                dec_q;
    logic                skid_valid;
    logic [31:0]         skid_ir;
    logic [PC_WIDTH-1:0] skid_pc;
    logic                rdy_q;

    logic                out_free, acc, load, skid_load, skid_nxt;
    logic [31:0]         src_ir;
    logic [PC_WIDTH-1:0] src_pc;

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = !flush && (SKID ? rdy_q : out_free);
    assign acc       = in_valid && in_ready;
    // The skid entry always drains ahead of the input to keep order.
    assign src_ir    = skid_valid ? skid_ir : in_ir;
    assign src_pc    = skid_valid ? skid_pc : in_pc;
    assign load      = out_free && (skid_valid || acc);
    assign skid_load = !out_free && acc;
    assign skid_nxt  = !flush && (skid_load || (skid_valid && !out_free));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            ir_q        <= NOP;
            pc_q        <= BOOT_ADDR;
            dec_q       <= decode(NOP);
            skid_valid  <= 1'b0;
            skid_ir     <= NOP;
            skid_pc     <= BOOT_ADDR;
            rdy_q       <= 1'b0;
        end else begin
            skid_valid <= skid_nxt;
            rdy_q      <= !skid_nxt;
            if (skid_load) begin
                skid_ir <= in_ir;
                skid_pc <= in_pc;
            end
            if (flush || (out_free && !load)) begin
                out_valid_q <= 1'b0;
                ir_q        <= NOP;
                dec_q       <= decode(NOP);
            end else if (load) begin
                out_valid_q <= 1'b1;
                ir_q        <= src_ir;
                pc_q        <= src_pc;
                dec_q       <= decode(src_ir);
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ir      = ir_q;
    assign out_pc      = pc_q;
    assign out_rd      = dec_q.rd;
    assign out_rs1     = dec_q.rs1;
    assign out_rs2     = dec_q.rs2;
    assign out_imm     = dec_q.imm;
    assign out_funct   = dec_q.funct;
    assign out_target  = dec_q.target;
    assign out_illegal = dec_q.illegal;

endmodule

// File: tb/tb_rv_decode.sv
// Bench for rv_decode: a SKID=0 and a SKID=1 instance share one stimulus
// stream; each is tracked by a queue-of-held-words model.
`timescale 1ns/1ps
module tb_rv_decode;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [8:0]  BOOT0 = 9'h000;
    localparam logic [8:0]  BOOT1 = 9'h1A4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_ir = 32'h0;
    logic [8:0]  in_pc = 9'h0;

    logic        rdy [2];
    logic        ov  [2];
    logic [4:0]  rd  [2];
    logic [4:0]  rs1 [2];
    logic [4:0]  rs2 [2];
    logic [31:0] imm [2];
    logic [3:0]  fn  [2];
    logic [1:0]  tg  [2];
    logic        ill [2];
    logic [31:0] oir [2];
    logic [8:0]  opc [2];

    always #5 clk = ~clk;

    rv_decode #(.XLEN(32), .PC_WIDTH(9), .SKID(1'b0)) u0 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy[0]), .in_ir(in_ir), .in_pc(in_pc),
        .out_valid(ov[0]), .out_ready(out_ready),
        .out_rd(rd[0]), .out_rs1(rs1[0]), .out_rs2(rs2[0]), .out_imm(imm[0]),
        .out_funct(fn[0]), .out_target(tg[0]), .out_illegal(ill[0]),
        .out_ir(oir[0]), .out_pc(opc[0]));

    rv_decode #(.XLEN(32), .PC_WIDTH(9), .BOOT_ADDR(BOOT1), .SKID(1'b1)) u1 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy[1]), .in_ir(in_ir), .in_pc(in_pc),
        .out_valid(ov[1]), .out_ready(out_ready),
        .out_rd(rd[1]), .out_rs1(rs1[1]), .out_rs2(rs2[1]), .out_imm(imm[1]),
        .out_funct(fn[1]), .out_target(tg[1]), .out_illegal(ill[1]),
        .out_ir(oir[1]), .out_pc(opc[1]));

    typedef struct { logic [31:0] ir; logic [8:0] pc; } word_t;
    typedef struct packed {
        logic [4:0] rd, rs1, rs2; logic [31:0] imm; logic [3:0] funct; logic [1:0] tgt; logic ill;
    } exp_t;
    typedef struct {
        logic [31:0] ir; logic [4:0] rd; logic [31:0] imm; logic [3:0] fn; logic [1:0] tg; logic ill;
    } vec_t;

    word_t q0[$], q1[$];
    logic  after1 = 1'b0;
    int    n_cmp = 0, n_bad = 0;
    vec_t  tbl [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: field extraction by shifts/masks on a signed int.
    function automatic exp_t ref_dec(input logic [31:0] ir);
        exp_t e;
        int s, op, f3, hi;
        s  = ir;
        op = s & 127;
        f3 = (s >> 12) & 7;
        hi = (s >> 30) & 1;
        e.rd = 5'((s >> 7) & 31); e.rs1 = 5'((s >> 15) & 31); e.rs2 = 5'((s >> 20) & 31);
        e.imm = 0; e.funct = 0; e.tgt = 2; e.ill = 0;
        case (op)
            'h13: begin e.imm = s >>> 20; e.funct = 4'((f3 == 5) ? hi * 8 + f3 : f3); end
            'h03: e.imm = s >>> 20;
            'h67: begin e.imm = s >>> 20; e.tgt = 0; end
            'h23: e.imm = ((s >>> 25) * 32) + ((s >> 7) & 31);
            'h63: begin
                e.imm = ((s >>> 31) * 4096) + (((s >> 7) & 1) * 2048)
                      + (((s >> 25) & 63) * 32) + (((s >> 8) & 15) * 2);
                e.tgt = 1;
            end
            'h37, 'h17: e.imm = s & 32'hFFFF_F000;
            'h6F: begin
                e.imm = ((s >>> 31) * (1 << 20)) + (((s >> 12) & 255) * 4096)
                      + (((s >> 20) & 1) * 2048) + (((s >> 21) & 1023) * 2);
                e.tgt = 1;
            end
            'h33: e.funct = 4'(hi * 8 + f3);
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    task automatic check_out(input int id);
        word_t w;
        exp_t  e;
        logic  v;
        v = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
        w.ir = NOP; w.pc = 9'h0;
        if (v) begin
            if (id == 0) w = q0[0];
            else         w = q1[0];
        end
        e = ref_dec(w.ir);
        chk($sformatf("d%0d valid", id), ov[id], v);
        chk($sformatf("d%0d ir", id), oir[id], w.ir);
        chk($sformatf("d%0d rd", id), rd[id], e.rd);
        chk($sformatf("d%0d rs1", id), rs1[id], e.rs1);
        chk($sformatf("d%0d rs2", id), rs2[id], e.rs2);
        chk($sformatf("d%0d imm", id), imm[id], e.imm);
        chk($sformatf("d%0d funct", id), fn[id], e.funct);
        chk($sformatf("d%0d target", id), tg[id], e.tgt);
        chk($sformatf("d%0d illegal", id), ill[id], e.ill);
        if (v) chk($sformatf("d%0d pc", id), opc[id], w.pc);
    endtask

    // One clock: check outputs, drive inputs, check in_ready, advance the models.
    task automatic cycle(input logic v, input logic [31:0] ir, input logic [8:0] pc,
                         input logic ordy, input logic fl);
        logic er0, er1;
        @(negedge clk);
        check_out(0);
        check_out(1);
        in_valid = v; in_ir = ir; in_pc = pc; out_ready = ordy; flush = fl;
        er0 = !fl && (q0.size() == 0 || ordy);
        er1 = !fl && after1 && (q1.size() < 2);
        #1;
        chk("d0 in_ready", rdy[0], er0);
        chk("d1 in_ready", rdy[1], er1);
        @(posedge clk);
        if (fl) begin
            q0.delete(); q1.delete();
        end else begin
            if (q0.size() > 0 && ordy) void'(q0.pop_front());
            if (q1.size() > 0 && ordy) void'(q1.pop_front());
            if (v && er0) q0.push_back('{ir, pc});
            if (v && er1) q1.push_back('{ir, pc});
        end
        after1 = 1'b1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("d1 in_ready first cycle after reset", rdy[1], 1'b0);
        @(posedge clk);
        #1;
        after1 = 1'b1;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [6:0]  ops [9];
        logic [31:0] ir;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        ir = $urandom;
        if ($urandom_range(0, 4) != 0) ir[6:0] = ops[$urandom_range(0, 8)];
        return ir;
    endfunction

    initial begin
        tbl[0]  = '{32'hFFF00093, 5'd1,  32'hFFFFFFFF, 4'h0, 2'd2, 1'b0};
        tbl[1]  = '{32'hFE000EE3, 5'd29, 32'hFFFFFFFC, 4'h0, 2'd1, 1'b0};
        tbl[2]  = '{32'h40205033, 5'd0,  32'h00000000, 4'hD, 2'd2, 1'b0};
        tbl[3]  = '{32'h4020D093, 5'd1,  32'h00000402, 4'hD, 2'd2, 1'b0};
        tbl[4]  = '{32'h00000000, 5'd0,  32'h00000000, 4'h0, 2'd2, 1'b1};
        tbl[5]  = '{32'h0000007F, 5'd0,  32'h00000000, 4'h0, 2'd2, 1'b1};
        tbl[6]  = '{32'h12345037, 5'd0,  32'h12345000, 4'h0, 2'd2, 1'b0};
        tbl[7]  = '{32'h008000EF, 5'd1,  32'h00000008, 4'h0, 2'd1, 1'b0};
        tbl[8]  = '{32'h000080E7, 5'd1,  32'h00000000, 4'h0, 2'd0, 1'b0};
        tbl[9]  = '{32'hFE112E23, 5'd28, 32'hFFFFFFFC, 4'h0, 2'd2, 1'b0};
        tbl[10] = '{32'h002081B3, 5'd3,  32'h00000000, 4'h0, 2'd2, 1'b0};
        tbl[11] = '{32'h40208133, 5'd2,  32'h00000000, 4'h8, 2'd2, 1'b0};
        tbl[12] = '{32'h40004013, 5'd0,  32'h00000400, 4'h4, 2'd2, 1'b0};
        tbl[13] = '{32'h0040A103, 5'd2,  32'h00000004, 4'h0, 2'd2, 1'b0};
        tbl[14] = '{32'hFFFFF097, 5'd1,  32'hFFFFF000, 4'h0, 2'd2, 1'b0};
        tbl[15] = '{32'h00000011, 5'd0,  32'h00000000, 4'h0, 2'd2, 1'b1};

        // Reset values
        #12;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst d%0d valid", d), ov[d], 1'b0);
            chk($sformatf("rst d%0d ir", d), oir[d], NOP);
            chk($sformatf("rst d%0d rd/rs1/rs2", d), {rd[d], rs1[d], rs2[d]}, 15'h0);
            chk($sformatf("rst d%0d imm", d), imm[d], 32'h0);
            chk($sformatf("rst d%0d funct", d), fn[d], 4'h0);
            chk($sformatf("rst d%0d target", d), tg[d], 2'd2);
            chk($sformatf("rst d%0d illegal", d), ill[d], 1'b0);
        end
        chk("rst d0 pc", opc[0], BOOT0);
        chk("rst d1 pc", opc[1], BOOT1);
        chk("rst d0 in_ready", rdy[0], 1'b1);
        chk("rst d1 in_ready", rdy[1], 1'b0);
        release_reset();

        // Directed decode table, one word per cycle with the output draining
        for (int i = 0; i < 16; i++) begin
            logic [8:0] p;
            p = 9'(i * 4);
            cycle(1'b1, tbl[i].ir, p, 1'b1, 1'b0);
            #2;
            chk($sformatf("tbl%0d valid", i), ov[0], 1'b1);
            chk($sformatf("tbl%0d ir", i), oir[0], tbl[i].ir);
            chk($sformatf("tbl%0d pc", i), opc[0], p);
            chk($sformatf("tbl%0d rd", i), rd[0], tbl[i].rd);
            chk($sformatf("tbl%0d imm", i), imm[0], tbl[i].imm);
            chk($sformatf("tbl%0d funct", i), fn[0], tbl[i].fn);
            chk($sformatf("tbl%0d target", i), tg[0], tbl[i].tg);
            chk($sformatf("tbl%0d illegal", i), ill[0], tbl[i].ill);
        end
        cycle(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);

        // Flush while holding a stalled word with a new word offered
        cycle(1'b1, 32'h00100093, 9'h010, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200113, 9'h014, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300193, 9'h018, 1'b0, 1'b1);
        #2;
        chk("flush d0 valid", ov[0], 1'b0);
        chk("flush d0 ir", oir[0], NOP);
        chk("flush d1 valid", ov[1], 1'b0);
        cycle(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);

        // Random streaming with random back-pressure and occasional flush
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, rand_ir(), 9'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);

        // Asynchronous reset between edges while words are held
        cycle(1'b1, 32'h00500293, 9'h040, 1'b0, 1'b0);
        cycle(1'b1, 32'h00600313, 9'h044, 1'b0, 1'b0);
        cycle(1'b1, 32'h00700393, 9'h048, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        chk("pre-areset d0 valid", ov[0], 1'b1);
        chk("pre-areset d1 valid", ov[1], 1'b1);
        resetn = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("areset d0 valid", ov[0], 1'b0);
        chk("areset d1 valid", ov[1], 1'b0);
        chk("areset d0 pc", opc[0], BOOT0);
        chk("areset d1 pc", opc[1], BOOT1);
        chk("areset d0 ir", oir[0], NOP);
        chk("areset d1 in_ready", rdy[1], 1'b0);
        q0.delete(); q1.delete();
        after1 = 1'b0;
        release_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 9'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
